data_mem_bank: RTL and testbench

//  Parametrised synchronous data memory for the MEM stage of the 32-bit pipelined core.

---
 rtl/data_mem_bank.sv | 129 ++++++++++++
 tb/tb_data_mem_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bank.sv
// Parametrised data memory for the MEM stage: byte-enabled writes, registered reads with
// a valid strobe, out-of-range detection and an optional post-reset zeroing sweep.
`timescale 1ns/1ps

module data_mem_bank #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  memwr,
  input  logic                  memrd,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data,
  output logic [DATA_W-1:0]     datao,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [DATA_W-1:0]   datao_reg;
  logic                rd_valid_reg;
  logic                err_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready;
  logic                in_range;
  logic                clr_fire;
  logic                wr_fire;
  logic                rd_fire;
  logic                bad_req;
  logic [ADDR_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged;

  // Address decode and request qualification
  assign ready    = (state_reg == ST_READY);
  assign in_range = ({1'b0, address} < DEPTH_EXT);
  assign clr_fire = (state_reg == ST_INIT);
  assign wr_fire  = ready && memwr && in_range;
  assign rd_fire  = ready && memrd;
  assign bad_req  = ready && (memwr || memrd) && !in_range;
  assign rd_idx   = in_range ? address : '0;
  assign rd_word  = mem[rd_idx];

  // Write-first: a read to the word being written sees the newly enabled bytes.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign merged[8*gi +: 8] = (wr_fire && be[gi]) ? data[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_INIT: begin
        ptr_next = ptr_reg + 1'b1;
        if (ptr_reg == LAST_PTR) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Storage array: no reset, zeroed by the sweep when enabled.
  always_ff @(posedge clk) begin
    if (clr_fire) begin
      mem[ptr_reg] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[address][8*i +: 8] <= data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      datao_reg    <= '0;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      err_reg      <= bad_req;
      if (rd_fire) begin
        datao_reg <= in_range ? merged : '0;
      end
    end
  end

  assign datao    = datao_reg;
  assign rd_valid = rd_valid_reg;
  assign err      = err_reg;
  assign busy     = (state_reg == ST_INIT);

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed self-checking bench for data_mem_bank (DEPTH=40 with clear sweep, plus a
// second instance without the sweep sharing the same inputs).
`timescale 1ns/1ps

module tb_data_mem_bank;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        memwr = 1'b0;
  logic        memrd = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [5:0]  address = 6'd0;
  logic [31:0] data = 32'h0;
  logic [31:0] datao, datao2;
  logic        rd_valid, busy, err;
  logic        rd_valid2, busy2, err2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_bank #(.DATA_W(32), .ADDR_W(6), .DEPTH(40), .INIT_CLEAR(1)) dut (
    .clk(clk), .res(res), .memwr(memwr), .memrd(memrd), .be(be),
    .address(address), .data(data), .datao(datao), .rd_valid(rd_valid),
    .busy(busy), .err(err)
  );

  data_mem_bank #(.DATA_W(32), .ADDR_W(6), .DEPTH(40), .INIT_CLEAR(0)) dut_noclr (
    .clk(clk), .res(res), .memwr(memwr), .memrd(memrd), .be(be),
    .address(address), .data(data), .datao(datao2), .rd_valid(rd_valid2),
    .busy(busy2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic exp_err);
    address = a; data = d; be = b; memwr = 1'b1;
    cyc();
    memwr = 1'b0;
    chk("wr_err", err, exp_err);
    chk("wr_no_rv", rd_valid, 1'b0);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp_d, input logic exp_err);
    address = a; memrd = 1'b1;
    cyc();
    memrd = 1'b0;
    chk("rd_valid", rd_valid, 1'b1);
    chk("rd_data", datao, exp_d);
    chk("rd_err", err, exp_err);
    cyc();
    chk("rd_valid_drop", rd_valid, 1'b0);
    chk("rd_hold", datao, exp_d);
    chk("rd_err_drop", err, 1'b0);
  endtask

  // Counts clock edges until busy drops; optionally checks that held requests stay ignored.
  task automatic wait_init(input logic hold);
    int n;
    n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
      if (hold) begin
        chk("init_no_rv", rd_valid, 1'b0);
        chk("init_no_err", err, 1'b0);
      end
    end
    memwr = 1'b0;
    memrd = 1'b0;
    chk("busy_cycles", n, 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and first clear sweep
    #1 res = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b1);
    chk("rst_datao", datao, 32'h0);
    chk("rst_rv", rd_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy_noclr", busy2, 1'b0);
    #5 res = 1'b1;
    wait_init(1'b0);
    rd(6'd0, 32'h0, 1'b0);
    rd(6'd39, 32'h0, 1'b0);
    rd(6'd17, 32'h0, 1'b0);

    // Full-word write and read back
    wr(6'd5, 32'd9, 4'hF, 1'b0);
    rd(6'd5, 32'd9, 1'b0);
    rd(6'd4, 32'h0, 1'b0);

    // Byte enables
    wr(6'd4, 32'hAABBCCDD, 4'hF, 1'b0);
    wr(6'd4, 32'h11223344, 4'b0101, 1'b0);
    rd(6'd4, 32'hAA22CC44, 1'b0);
    wr(6'd4, 32'h00000000, 4'h0, 1'b0);
    rd(6'd4, 32'hAA22CC44, 1'b0);

    // Back-to-back reads
    address = 6'd5; memrd = 1'b1;
    cyc();
    chk("b2b_first", datao, 32'd9);
    address = 6'd4;
    cyc();
    memrd = 1'b0;
    chk("b2b_second", datao, 32'hAA22CC44);
    chk("b2b_rv", rd_valid, 1'b1);

    // Range boundary and out-of-range
    wr(6'd34, 32'd1, 4'hF, 1'b0);
    rd(6'd34, 32'd1, 1'b0);
    wr(6'd50, 32'd7, 4'hF, 1'b1);
    rd(6'd50, 32'h0, 1'b1);
    rd(6'd18, 32'h0, 1'b0);
    rd(6'd10, 32'h0, 1'b0);
    wr(6'd39, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(6'd39, 32'hDEADBEEF, 1'b0);

    // Same-cycle write and read, write-first
    wr(6'd9, 32'h3, 4'hF, 1'b0);
    address = 6'd9; data = 32'h5A; be = 4'hF; memwr = 1'b1; memrd = 1'b1;
    cyc();
    memwr = 1'b0; memrd = 1'b0;
    chk("wf_data", datao, 32'h5A);
    chk("wf_rv", rd_valid, 1'b1);
    chk("wf_err", err, 1'b0);
    address = 6'd9; data = 32'h0000FF00; be = 4'b0010; memwr = 1'b1; memrd = 1'b1;
    cyc();
    memwr = 1'b0; memrd = 1'b0;
    chk("wf_merge", datao, 32'h0000FF5A);
    rd(6'd9, 32'h0000FF5A, 1'b0);

    // Reset during READY, then reset again mid-sweep with requests held
    res = 1'b0;
    #1;
    chk("rst2_busy", busy, 1'b1);
    chk("rst2_datao", datao, 32'h0);
    chk("rst2_rv", rd_valid, 1'b0);
    chk("rst2_busy_noclr", busy2, 1'b0);
    #6 res = 1'b1;
    address = 6'd9; data = 32'hFF; be = 4'hF; memwr = 1'b1; memrd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("pre_rst_no_rv", rd_valid, 1'b0);
    end
    res = 1'b0;
    #3 res = 1'b1;
    chk("midinit_busy", busy, 1'b1);
    wait_init(1'b1);
    chk("noclr_busy_after", busy2, 1'b0);
    rd(6'd9, 32'h0, 1'b0);
    rd(6'd39, 32'h0, 1'b0);
    rd(6'd5, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
